// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares one single-port SDRAM controller between two requesters (port 0 =
// test engine, port 1 = UART/CPU side) and schedules periodic auto-refresh.
// Refresh has top priority; the two ports alternate fairly on a tie. Only one
// transaction (port or refresh) is outstanding at the controller at a time.
//
// Ports:
//   clk, reset_in                  system clock, async active-low reset
//   reqN/weN/addrN/wdataN/bytesel  port N request, held until ackN
//   ackN, rdataN                   port N one-cycle completion + read data
//   ctl_req/ctl_refresh/ctl_we/    request to the SDRAM controller, held
//   ctl_addr/ctl_wdata/ctl_bytesel until ctl_ack
//   ctl_ack, ctl_rdata             controller completion + read data
//   grant                          one-hot owner of in-flight port transaction
//   refresh_miss                   sticky refresh-overrun flag
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int unsigned addr_width       = 24,
  parameter int unsigned data_width       = 16,
  parameter int unsigned refresh_interval = 390
) (
  input  logic                  clk,
  input  logic                  reset_in,

  input  logic                  req0,
  input  logic                  we0,
  input  logic [addr_width-1:0] addr0,
  input  logic [data_width-1:0] wdata0,
  input  logic [1:0]            bytesel0,
  output logic                  ack0,
  output logic [data_width-1:0] rdata0,

  input  logic                  req1,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata1,
  input  logic [1:0]            bytesel1,
  output logic                  ack1,
  output logic [data_width-1:0] rdata1,

  output logic                  ctl_req,
  output logic                  ctl_refresh,
  output logic                  ctl_we,
  output logic [addr_width-1:0] ctl_addr,
  output logic [data_width-1:0] ctl_wdata,
  output logic [1:0]            ctl_bytesel,
  input  logic                  ctl_ack,
  input  logic [data_width-1:0] ctl_rdata,

  output logic [1:0]            grant,
  output logic                  refresh_miss
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [15:0] RELOAD = 16'(refresh_interval - 1);

  logic [1:0]            state_q, state_d;
  // Port index of the most recent grant; reset to 1 so port 0 wins first tie.
  logic                  last_grant_q, last_grant_d;
  // Port index of the in-flight port transaction.
  logic                  owner_q, owner_d;

  logic                  ctl_req_q, ctl_req_d;
  logic                  ctl_refresh_q, ctl_refresh_d;
  logic                  ctl_we_q, ctl_we_d;
  logic [addr_width-1:0] ctl_addr_q, ctl_addr_d;
  logic [data_width-1:0] ctl_wdata_q, ctl_wdata_d;
  logic [1:0]            ctl_bytesel_q, ctl_bytesel_d;

  logic [1:0]            grant_q, grant_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [data_width-1:0] rdata0_q, rdata0_d;
  logic [data_width-1:0] rdata1_q, rdata1_d;

  logic [15:0]           rcnt_q, rcnt_d;
  logic                  pend_q, pend_d;
  logic                  miss_q, miss_d;

  logic                  refresh_done;
  logic                  pick;

  // Tie goes to the port that did not win last; otherwise whichever asks.
  always_comb begin
    if (req0 && req1) begin
      pick = ~last_grant_q;
    end else begin
      pick = req1;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    ctl_req_d     = ctl_req_q;
    ctl_refresh_d = ctl_refresh_q;
    ctl_we_d      = ctl_we_q;
    ctl_addr_d    = ctl_addr_q;
    ctl_wdata_d   = ctl_wdata_q;
    ctl_bytesel_d = ctl_bytesel_q;
    grant_d       = grant_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    refresh_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          ctl_req_d     = 1'b1;
          ctl_refresh_d = 1'b1;
          ctl_we_d      = 1'b0;
          grant_d       = 2'b00;
          state_d       = ST_BUSY;
        end else if (req0 || req1) begin
          owner_d       = pick;
          last_grant_d  = pick;
          ctl_req_d     = 1'b1;
          ctl_refresh_d = 1'b0;
          if (pick) begin
            ctl_we_d      = we1;
            ctl_addr_d    = addr1;
            ctl_wdata_d   = wdata1;
            ctl_bytesel_d = bytesel1;
            grant_d       = 2'b10;
          end else begin
            ctl_we_d      = we0;
            ctl_addr_d    = addr0;
            ctl_wdata_d   = wdata0;
            ctl_bytesel_d = bytesel0;
            grant_d       = 2'b01;
          end
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (ctl_ack) begin
          ctl_req_d     = 1'b0;
          ctl_refresh_d = 1'b0;
          if (ctl_refresh_q) begin
            refresh_done = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            // Captured for writes too, so rdataN always tracks the last ack.
            if (owner_q) begin
              rdata1_d = ctl_rdata;
              ack1_d   = 1'b1;
            end else begin
              rdata0_d = ctl_rdata;
              ack0_d   = 1'b1;
            end
            state_d = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Refresh counter free-runs in every state. An expiry that coincides with
  // the refresh completing keeps the flag set and counts as a miss.
  always_comb begin
    rcnt_d = rcnt_q;
    pend_d = pend_q;
    miss_d = miss_q;
    if (rcnt_q == 16'd0) begin
      rcnt_d = RELOAD;
      pend_d = 1'b1;
      if (pend_q) begin
        miss_d = 1'b1;
      end
    end else begin
      rcnt_d = rcnt_q - 16'd1;
      if (refresh_done) begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      ctl_req_q     <= 1'b0;
      ctl_refresh_q <= 1'b0;
      ctl_we_q      <= 1'b0;
      ctl_addr_q    <= '0;
      ctl_wdata_q   <= '0;
      ctl_bytesel_q <= '0;
      grant_q       <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      rcnt_q        <= RELOAD;
      pend_q        <= 1'b0;
      miss_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      ctl_req_q     <= ctl_req_d;
      ctl_refresh_q <= ctl_refresh_d;
      ctl_we_q      <= ctl_we_d;
      ctl_addr_q    <= ctl_addr_d;
      ctl_wdata_q   <= ctl_wdata_d;
      ctl_bytesel_q <= ctl_bytesel_d;
      grant_q       <= grant_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      rcnt_q        <= rcnt_d;
      pend_q        <= pend_d;
      miss_q        <= miss_d;
    end
  end

  assign ctl_req      = ctl_req_q;
  assign ctl_refresh  = ctl_refresh_q;
  assign ctl_we       = ctl_we_q;
  assign ctl_addr     = ctl_addr_q;
  assign ctl_wdata    = ctl_wdata_q;
  assign ctl_bytesel  = ctl_bytesel_q;
  assign grant        = grant_q;
  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign refresh_miss = miss_q;

endmodule
